// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_seq                                                       |
// | Brief    : Registered ALU with valid/ready handshake, shift-add MUL and  |
// |            optional restoring DIV (enabled by macro ALU_SEQ_DIV_EN).     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] E_hi,
    output logic [1:0]       cc,
    output logic             err
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [OPW-1:0] c_OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] c_OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] c_OP_AND = OPW'(2);
    localparam logic [OPW-1:0] c_OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] c_OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] c_OP_NOT = OPW'(5);
    localparam logic [OPW-1:0] c_OP_SHL = OPW'(6);
    localparam logic [OPW-1:0] c_OP_SHR = OPW'(7);
    localparam logic [OPW-1:0] c_OP_MUL = OPW'(8);
    localparam logic [OPW-1:0] c_OP_DIV = OPW'(9);

`ifdef ALU_SEQ_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_div0;
    logic               w_multi;
    logic               w_last;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_e;
    logic [WIDTH-1:0]   w_hi;
    logic               w_c;
    logic               w_err;

    logic [WIDTH:0]     w_msum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;

    assign w_accept = in_valid & in_ready;
    assign w_is_mul = (op == c_OP_MUL);
    assign w_is_div = c_DIV_EN && (op == c_OP_DIV);
    assign w_div0   = w_is_div && (B == '0);
    assign w_multi  = w_is_mul | (w_is_div & ~w_div0);
    assign w_last   = (r_cnt == c_CNT_W'(WIDTH - 1));

    // Single-cycle results, registered directly on the accept edge
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        w_e   = '0;
        w_hi  = '0;
        w_c   = 1'b0;
        w_err = 1'b0;
        case (op)
            c_OP_ADD: begin w_e = w_sum[WIDTH-1:0];  w_c = w_sum[WIDTH];  end
            c_OP_SUB: begin w_e = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH]; end
            c_OP_AND: w_e = A & B;
            c_OP_OR:  w_e = A | B;
            c_OP_XOR: w_e = A ^ B;
            c_OP_NOT: w_e = ~A;
            c_OP_SHL: begin w_e = {A[WIDTH-2:0], 1'b0}; w_c = A[WIDTH-1]; end
            c_OP_SHR: begin w_e = {1'b0, A[WIDTH-1:1]}; w_c = A[0];       end
            default:  w_err = 1'b1;
        endcase
        if (w_div0) begin
            w_e   = '1;
            w_hi  = A;
            w_c   = 1'b1;
            w_err = 1'b1;
        end
    end

    // Shift-add step: {r_hi, r_lo} holds partial product over multiplier bits
    assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_mul_hi = w_msum[WIDTH:1];
    assign w_mul_lo = {w_msum[0], r_lo[WIDTH-1:1]};

    generate
        if (c_DIV_EN) begin : g_div
            logic [WIDTH-1:0] r_b;
            logic [WIDTH:0]   w_dshift;
            logic [WIDTH:0]   w_ddiff;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_b <= '0;
                end else if (w_accept) begin
                    r_b <= B;
                end
            end

            // Restoring step: r_hi is the remainder, r_lo shifts dividend out / quotient in
            assign w_dshift = {r_hi, r_lo[WIDTH-1]};
            assign w_ddiff  = w_dshift - {1'b0, r_b};
            assign w_div_hi = w_ddiff[WIDTH] ? w_dshift[WIDTH-1:0] : w_ddiff[WIDTH-1:0];
            assign w_div_lo = {r_lo[WIDTH-2:0], ~w_ddiff[WIDTH]};
        end else begin : g_no_div
            assign w_div_hi = '0;
            assign w_div_lo = '0;
        end
    endgenerate

    assign w_step_hi = r_is_div ? w_div_hi : w_mul_hi;
    assign w_step_lo = r_is_div ? w_div_lo : w_mul_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = w_multi ? c_EXEC : c_DONE;
            c_EXEC:  if (w_last) w_state_nxt = c_DONE;
            c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            E        <= '0;
            E_hi     <= '0;
            cc       <= 2'b00;
            err      <= 1'b0;
        end else if (w_accept) begin
            r_a      <= A;
            r_is_div <= w_is_div;
            r_cnt    <= '0;
            if (w_multi) begin
                r_hi <= '0;
                r_lo <= w_is_div ? A : B;
            end else begin
                E    <= w_e;
                E_hi <= w_hi;
                cc   <= {w_c, (w_e == '0)};
                err  <= w_err;
            end
        end else if (r_state == c_EXEC) begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                E    <= w_step_lo;
                E_hi <= w_step_hi;
                cc   <= {(~r_is_div & (w_step_hi != '0)), (w_step_lo == '0)};
                err  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU (A, B, op[3:0] -> E, cc[1:0]).
- Adds a valid/ready handshake on both sides, registered result and condition codes, and a multi-cycle shift-add multiplier.
- A restoring divider is optional.
- Sits between the register file/operand latch and the writeback path of the tiny CPU datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (min 4).
- OPW, 4, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode offer.
- in_ready  out  1  block can accept an operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- op  in  OPW  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- E  out  WIDTH  result (low half for MUL).
- E_hi  out  WIDTH  high half of MUL product, remainder for DIV, 0 otherwise.
- cc  out  2  condition codes: cc[0]=zero (E==0), cc[1]=carry/borrow/overflow.
- err  out  1  illegal opcode, or divide by zero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; E=0; E_hi=0; cc=00; err=0. Internal counters and accumulators are cleared. An operation in flight is discarded with no output.
- Acceptance: an operation is accepted on a rising edge where in_valid & in_ready. A, B and op are captured into internal registers, and later input changes have no effect.
- Opcodes:
  - 0 ADD: {cc[1],E}=A+B.
  - 1 SUB: E=A-B, cc[1]=borrow (A<B).
  - 2 AND, 3 OR, 4 XOR: bitwise; cc[1]=0.
  - 5 NOT: E=~A; cc[1]=0.
  - 6 SHL: E=A<<1; cc[1]=A[WIDTH-1].
  - 7 SHR: E=A>>1 (logical); cc[1]=A[0].
  - 8 MUL: unsigned, {E_hi,E}=A*B; cc[1]=(E_hi!=0).
  - 9 DIV: see Optional Feature.
  - Any other opcode: E=0, E_hi=0, err=1, cc=01.
- cc[0] always reflects E==0 only; E_hi does not affect it.
- State machine: IDLE -> EXEC (MUL/DIV only) -> DONE -> IDLE.
  - IDLE: in_ready=1. A single-cycle op (0-7, illegal) goes directly to DONE, with E/cc/err registered on the same accept edge. MUL/DIV goes to EXEC with count=0.
  - EXEC: in_ready=0, out_valid=0. One shift-add (or restore-subtract) step per cycle. After exactly WIDTH steps the final result is registered and the state becomes DONE.
  - DONE: out_valid=1, in_ready=0. E/E_hi/cc/err are held stable until out_ready=1. On the edge with out_valid & out_ready the state returns to IDLE and out_valid falls.
- Latency from accept edge to out_valid=1: 1 cycle for simple ops and illegal opcodes, WIDTH+1 cycles for MUL/DIV.
- Minimum issue interval: 2 cycles for simple ops. There is no overlap of accept and retire.
- Outputs hold their last value in IDLE and EXEC. Only out_valid qualifies them.
- All arithmetic is unsigned and wraps modulo 2^WIDTH. The carry is the (WIDTH+1)th bit.
- in_valid while not in_ready: ignored. The producer must hold it.
- out_ready while not out_valid: ignored.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: op 9 DIV is unsigned restoring division, WIDTH cycles in EXEC. E=quotient, E_hi=remainder, cc[1]=0.
  - B==0: skip EXEC and go to DONE next cycle, with E={WIDTH{1}}, E_hi=A, err=1, cc[1]=1.
- Undefined: op 9 is an illegal opcode (E=0, E_hi=0, err=1, cc=01, 1-cycle latency). No divider logic is synthesised.

Test Plan:
- WIDTH=8, A=1, B=2, op=0, out_ready=1 -> out_valid one cycle after accept, E=0x03, cc=00, err=0; in_ready back to 1 the next cycle.
- A=2, B=3, op=1 -> E=0xFF, cc=10. Then A=5, B=5, op=1 -> E=0x00, cc=01.
- A=200, B=3, op=8 -> in_ready=0 for 9 cycles; out_valid on cycle 9 after accept; E=0x58, E_hi=0x02, cc=10.
- Backpressure: op=4, A=0xF0, B=0xFF, out_ready=0 for 5 cycles -> out_valid stays 1, E=0x0F stable, in_valid pulses are ignored; out_ready=1 -> return to IDLE.
- Reset mid-op: start MUL, assert rst_n=0 at cycle 4 of EXEC -> out_valid=0, E=0, cc=00 immediately (async); after release, in_ready=1 and a fresh ADD 7+9 gives E=0x10.
- op=0xF -> err=1, E=0, cc=01. With ALU_SEQ_DIV_EN: A=100, B=7, op=9 -> E=14, E_hi=2, err=0; B=0 -> E=0xFF, E_hi=100, err=1.
